// File: rtl/udp_frame_sequencer.sv
// Beat-level sequencer for Eth/IPv4/UDP frames on a 64-bit stream: tracks beat index,
// filters on EtherType/protocol/port and forwards the UDP payload with byte enables.
//
// state   | meaning
// IDLE    | waiting for sop; non-sop beats discarded
// HDR     | header beats 0..5, field checks; beat 5 may carry first payload bytes
// PAYLOAD | forwarding payload until UDP length exhausted
// DROP    | discarding rest of frame (padding / rejected) until eop
module udp_frame_sequencer #(
  parameter logic [15:0] UDP_PORT  = 16'd26400,
  parameter bit          FILTER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  input  logic        out_ready,
  output logic [3:0]  beat_idx,
  output logic        hdr_valid,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_last,
  output logic        err_hdr,
  output logic        err_trunc,
  output logic        err_abort,
  output logic        drop_flt,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] rem, rem_n;
  logic        hv_n, ehdr_n, etrunc_n, eabort_n, flt_n, fcnt_inc;
  logic        emit5, emit, accept, last_c, hdr_fail;
  logic [3:0]  nbytes, lo;
  logic [15:0] rem_after;
  logic [7:0]  keep_c;
  logic [15:0] ethertype, dport, udp_len;
  logic [7:0]  ip_proto;

  // Fields are big-endian: the lower lane holds the more significant byte.
  assign ethertype = {in_data[39:32], in_data[47:40]};
  assign dport     = {in_data[39:32], in_data[47:40]};
  assign udp_len   = {in_data[55:48], in_data[63:56]};
  assign ip_proto  = in_data[63:56];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      hdr_valid <= 1'b0;
      err_hdr   <= 1'b0;
      err_trunc <= 1'b0;
      err_abort <= 1'b0;
      drop_flt  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rem       <= rem_n;
      hdr_valid <= hv_n;
      err_hdr   <= ehdr_n;
      err_trunc <= etrunc_n;
      err_abort <= eabort_n;
      drop_flt  <= flt_n;
      frame_cnt <= frame_cnt + {15'd0, fcnt_inc};
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    hv_n     = 1'b0;
    ehdr_n   = 1'b0;
    etrunc_n = 1'b0;
    eabort_n = 1'b0;
    flt_n    = 1'b0;
    fcnt_inc = 1'b0;
    hdr_fail = ((cnt == 4'd1) && (ethertype != 16'h0800)) ||
               ((cnt == 4'd2) && (ip_proto != 8'h11)) ||
               ((cnt == 4'd4) && FILTER_EN && (dport != UDP_PORT));
    if (accept) begin
      if (in_sop) begin
        eabort_n = (state != IDLE);
        rem_n    = '0;
        cnt_n    = 4'd1;
        if (in_eop) begin
          ehdr_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = HDR;
        end
      end else begin
        cnt_n = (cnt == 4'd15) ? cnt : cnt + 4'd1;
        if (emit) begin
          hv_n  = (state == HDR);
          rem_n = rem_after;
          if (rem_after == 16'd0) begin
            fcnt_inc = 1'b1;
            state_n  = in_eop ? IDLE : DROP;
          end else if (in_eop) begin
            etrunc_n = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n = PAYLOAD;
          end
        end else begin
          case (state)
            HDR: begin
              if (cnt < 4'd5) begin
                if (hdr_fail) begin
                  flt_n   = 1'b1;
                  state_n = in_eop ? IDLE : DROP;
                end else if ((cnt == 4'd4) && (udp_len < 16'd8)) begin
                  ehdr_n  = 1'b1;
                  state_n = in_eop ? IDLE : DROP;
                end else if (in_eop) begin
                  ehdr_n  = 1'b1;
                  state_n = IDLE;
                end else if (cnt == 4'd4) begin
                  rem_n = udp_len - 16'd8;
                end
              end else begin
                // Header accepted but zero-length payload.
                hv_n    = 1'b1;
                state_n = in_eop ? IDLE : DROP;
              end
            end
            DROP:    if (in_eop) state_n = IDLE;
            default: state_n = IDLE;
          endcase
        end
      end
      if (state_n == IDLE) cnt_n = '0;
    end
  end

  always_comb begin
    emit5 = (state == HDR) && !in_sop && (cnt == 4'd5) && (rem != 16'd0);
    emit  = !rst && (emit5 || ((state == PAYLOAD) && !in_sop));
    if (emit5) nbytes = (rem > 16'd6) ? 4'd6 : rem[3:0];
    else       nbytes = (rem > 16'd8) ? 4'd8 : rem[3:0];
    lo = emit5 ? 4'd2 : 4'd0;
    for (int k = 0; k < 8; k++) keep_c[k] = (4'(k) >= lo) && (4'(k) < lo + nbytes);
    rem_after = rem - {12'd0, nbytes};
    last_c    = (rem_after == 16'd0) || in_eop;
    in_ready  = rst ? 1'b0 : (emit ? out_ready : 1'b1);
    accept    = in_valid && in_ready;
    out_valid = in_valid && emit;
    out_data  = out_valid ? in_data : '0;
    out_keep  = out_valid ? keep_c : '0;
    out_last  = out_valid && last_c;
    beat_idx  = in_sop ? 4'd0 : cnt;
  end

endmodule

// File: tb/tb_udp_frame_sequencer.sv
// Bench for udp_frame_sequencer: directed frame table plus random frames, all checked
// per cycle against a byte-offset reference model (payload = frame bytes 42 .. 42+len-9).
module tb_udp_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sop, in_eop, out_ready;
  logic [63:0] in_data;
  logic        in_ready, hdr_valid, out_valid, out_last;
  logic        err_hdr, err_trunc, err_abort, drop_flt;
  logic [3:0]  beat_idx;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic [15:0] frame_cnt;

  logic        nf_in_ready, nf_hdr_valid, nf_out_valid, nf_out_last;
  logic        nf_err_hdr, nf_err_trunc, nf_err_abort, nf_drop_flt;
  logic [3:0]  nf_beat_idx;
  logic [63:0] nf_out_data;
  logic [7:0]  nf_out_keep;
  logic [15:0] nf_frame_cnt;

  always #5 clk = ~clk;

  udp_frame_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .out_ready(out_ready), .beat_idx(beat_idx),
    .hdr_valid(hdr_valid), .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .err_hdr(err_hdr), .err_trunc(err_trunc), .err_abort(err_abort),
    .drop_flt(drop_flt), .frame_cnt(frame_cnt)
  );

  udp_frame_sequencer #(.FILTER_EN(1'b0)) u_nf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(nf_in_ready), .out_ready(out_ready), .beat_idx(nf_beat_idx),
    .hdr_valid(nf_hdr_valid), .out_valid(nf_out_valid), .out_data(nf_out_data),
    .out_keep(nf_out_keep), .out_last(nf_out_last), .err_hdr(nf_err_hdr),
    .err_trunc(nf_err_trunc), .err_abort(nf_err_abort), .drop_flt(nf_drop_flt),
    .frame_cnt(nf_frame_cnt)
  );

  int total = 0;
  int bad   = 0;

  // reference model state: m_b = index of next beat (-1 outside a frame)
  int          m_b = -1;
  bit          m_drop;
  int          m_plen;
  logic [15:0] m_fcnt = '0;
  bit          e_hv, e_hdr, e_trunc, e_abort, e_flt;

  int          obs_n, obs_last, obs_hv, obs_flt, obs_ehdr, obs_trunc, obs_abort, nf_n;
  logic [31:0] obs_keeps;
  bit          tog;

  typedef struct {
    logic [15:0] et;
    logic [7:0]  pr;
    logic [15:0] port;
    logic [15:0] len;
    int          last_beat;
    int          rmode;
    int          n_out;
    logic [31:0] keeps;
    int          hv, flt, ehdr, trunc, fdelta;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic ref_beat(input bit sop, input bit eop, input logic [63:0] d, input bit commit,
                          output bit emit, output logic [7:0] keep, output bit last,
                          output logic [3:0] idx);
    int b, lo, stop;
    bit has_end, fail;
    logic [15:0] ln;
    emit = 0; keep = '0; last = 0; has_end = 0;
    b = m_b;
    idx = (sop || b < 0) ? 4'd0 : ((b > 15) ? 4'd15 : 4'(b));
    if (sop) begin
      if (commit) begin
        e_abort = (b >= 0);
        if (eop) begin e_hdr = 1; m_b = -1; end
        else begin m_b = 1; m_drop = 0; m_plen = -1; end
      end
    end else if (b >= 0) begin
      if (!m_drop && b >= 5) begin
        lo = 8 * b;
        stop = 42 + m_plen;
        for (int k = 0; k < 8; k++) keep[k] = (lo + k >= 42) && (lo + k < stop);
        emit = (keep != 0);
        has_end = (m_plen > 0) && (stop - 1 >= lo) && (stop - 1 <= lo + 7);
        last = emit && (has_end || eop);
      end
      if (commit) begin
        if (!m_drop && b < 5) begin
          ln = {d[55:48], d[63:56]};
          fail = (b == 1 && {d[39:32], d[47:40]} != 16'h0800) ||
                 (b == 2 && d[63:56] != 8'h11) ||
                 (b == 4 && {d[39:32], d[47:40]} != 16'd26400);
          if (fail) begin e_flt = 1; m_drop = 1; end
          else if (b == 4 && ln < 16'd8) begin e_hdr = 1; m_drop = 1; end
          else if (eop) e_hdr = 1;
          else if (b == 4) m_plen = int'(ln) - 8;
        end else if (!m_drop) begin
          if (b == 5) e_hv = 1;
          if (emit && eop && !has_end) e_trunc = 1;
          if (has_end) m_fcnt++;
          if (has_end || m_plen == 0) m_drop = 1;
        end
        m_b = eop ? -1 : b + 1;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [63:0] d, input bit sop, input bit eop,
                       input bit rdy, output bit acc);
    bit emit, last, exp_rdy, ve;
    logic [7:0] keep;
    logic [3:0] idx;
    in_valid = v; in_data = d; in_sop = v & sop; in_eop = v & eop; out_ready = rdy;
    @(negedge clk);
    ref_beat(v & sop, v & eop, d, 1'b0, emit, keep, last, idx);
    exp_rdy = emit ? rdy : 1'b1;
    ve = v && emit;
    if (v) chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, ve);
    chk("out_keep", out_keep, ve ? keep : 8'h00);
    chk("out_last", out_last, ve && last);
    chk("out_data", out_data, ve ? d : 64'd0);
    chk("beat_idx", beat_idx, idx);
    if (out_valid && in_ready) begin
      obs_keeps = {obs_keeps[23:0], out_keep};
      obs_n++;
      obs_last += int'(out_last);
    end
    if (nf_out_valid && nf_in_ready) nf_n++;
    acc = v && exp_rdy;
    e_hv = 0; e_hdr = 0; e_trunc = 0; e_abort = 0; e_flt = 0;
    if (acc) ref_beat(v & sop, v & eop, d, 1'b1, emit, keep, last, idx);
    @(posedge clk);
    #1;
    chk("hdr_valid", hdr_valid, e_hv);
    chk("err_hdr", err_hdr, e_hdr);
    chk("err_trunc", err_trunc, e_trunc);
    chk("err_abort", err_abort, e_abort);
    chk("drop_flt", drop_flt, e_flt);
    chk("frame_cnt", frame_cnt, m_fcnt);
    obs_hv += int'(hdr_valid); obs_flt += int'(drop_flt); obs_ehdr += int'(err_hdr);
    obs_trunc += int'(err_trunc); obs_abort += int'(err_abort);
  endtask

  function automatic logic [63:0] mk_beat(int b, logic [15:0] et, logic [7:0] pr,
                                          logic [15:0] port, logic [15:0] len);
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (b == 1) begin r[39:32] = et[15:8]; r[47:40] = et[7:0]; end
    if (b == 2) r[63:56] = pr;
    if (b == 4) begin
      r[39:32] = port[15:8]; r[47:40] = port[7:0];
      r[55:48] = len[15:8];  r[63:56] = len[7:0];
    end
    return r;
  endfunction

  task automatic send_frame(input logic [15:0] et, input logic [7:0] pr, input logic [15:0] port,
                            input logic [15:0] len, input int last_beat, input int rmode,
                            input bit no_eop);
    logic [63:0] d;
    bit got, v, rdy;
    for (int b = 0; b <= last_beat; b++) begin
      d = mk_beat(b, et, pr, port, len);
      got = 0;
      for (int t = 0; t < 64 && !got; t++) begin
        v = 1; rdy = 1;
        if (rmode == 1) begin rdy = tog; tog = !tog; end
        if (rmode == 2) begin v = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 2) != 0); end
        cycle(v, d, b == 0, (b == last_beat) && !no_eop, rdy, got);
      end
      if (!got) begin
        total++; bad++;
        $display("FAIL beat_timeout: beat %0d not accepted within 64 cycles", b);
      end
    end
  endtask

  task automatic clr_obs();
    obs_n = 0; obs_last = 0; obs_hv = 0; obs_flt = 0; obs_ehdr = 0;
    obs_trunc = 0; obs_abort = 0; nf_n = 0; obs_keeps = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f0, nf0, et, pt, ln;
    logic [7:0]  pr;
    int          lb;
    bit          ab, dummy;

    vec[0]  = '{16'h0800, 8'h11, 16'd26400, 16'd34, 8,  0, 4, 32'hFCFFFF0F, 1, 0, 0, 0, 1};
    vec[1]  = '{16'h0800, 8'h11, 16'd1234,  16'd28, 7,  0, 0, 32'h0,        0, 1, 0, 0, 0};
    vec[2]  = '{16'h0800, 8'h11, 16'd26400, 16'd11, 7,  0, 1, 32'h0000001C, 1, 0, 0, 0, 1};
    vec[3]  = '{16'h0800, 8'h11, 16'd26400, 16'd48, 7,  0, 3, 32'h00FCFFFF, 1, 0, 0, 1, 0};
    vec[4]  = '{16'h0800, 8'h11, 16'd26400, 16'd34, 3,  0, 0, 32'h0,        0, 0, 1, 0, 0};
    vec[5]  = '{16'h86DD, 8'h11, 16'd26400, 16'd34, 7,  0, 0, 32'h0,        0, 1, 0, 0, 0};
    vec[6]  = '{16'h0800, 8'h06, 16'd26400, 16'd34, 7,  0, 0, 32'h0,        0, 1, 0, 0, 0};
    vec[7]  = '{16'h0800, 8'h11, 16'd26400, 16'd8,  6,  0, 0, 32'h0,        1, 0, 0, 0, 0};
    vec[8]  = '{16'h0800, 8'h11, 16'd26400, 16'd5,  6,  0, 0, 32'h0,        0, 0, 1, 0, 0};
    vec[9]  = '{16'h0800, 8'h11, 16'd26400, 16'd34, 8,  1, 4, 32'hFCFFFF0F, 1, 0, 0, 0, 1};
    vec[10] = '{16'h0800, 8'h11, 16'd26400, 16'd34, 10, 0, 4, 32'hFCFFFF0F, 1, 0, 0, 0, 1};
    vec[11] = '{16'h0800, 8'h11, 16'd26400, 16'd34, 4,  0, 0, 32'h0,        0, 0, 1, 0, 0};

    rst = 1; in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0; out_ready = 0; tog = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_beat_idx", beat_idx, 4'd0);
    chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    rst = 0;
    clr_obs();

    for (int i = 0; i < 12; i++) begin
      clr_obs();
      f0 = frame_cnt; nf0 = nf_frame_cnt;
      send_frame(vec[i].et, vec[i].pr, vec[i].port, vec[i].len, vec[i].last_beat, vec[i].rmode, 1'b0);
      chk($sformatf("v%0d_n_out", i), obs_n, vec[i].n_out);
      chk($sformatf("v%0d_keeps", i), obs_keeps, vec[i].keeps);
      chk($sformatf("v%0d_hdr_valid", i), obs_hv, vec[i].hv);
      chk($sformatf("v%0d_drop_flt", i), obs_flt, vec[i].flt);
      chk($sformatf("v%0d_err_hdr", i), obs_ehdr, vec[i].ehdr);
      chk($sformatf("v%0d_err_trunc", i), obs_trunc, vec[i].trunc);
      chk($sformatf("v%0d_fdelta", i), frame_cnt - f0, vec[i].fdelta);
      if (i == 1) begin
        chk("nofilter_n_out", nf_n, 3);
        chk("nofilter_fdelta", nf_frame_cnt - nf0, 1);
      end
    end

    // sop at beat 6 of a payload frame, then a clean frame
    clr_obs();
    f0 = frame_cnt;
    send_frame(16'h0800, 8'h11, 16'd26400, 16'd34, 6, 0, 1'b1);
    send_frame(16'h0800, 8'h11, 16'd26400, 16'd34, 8, 0, 1'b0);
    chk("abort_pulses", obs_abort, 1);
    chk("abort_lasts", obs_last, 1);
    chk("abort_fdelta", frame_cnt - f0, 1);

    // reset mid-payload
    send_frame(16'h0800, 8'h11, 16'd26400, 16'd34, 6, 0, 1'b1);
    rst = 1; in_valid = 0; in_sop = 0; in_eop = 0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_beat_idx", beat_idx, 4'd0);
    chk("midrst_frame_cnt", frame_cnt, 16'd0);
    chk("midrst_pulses", {hdr_valid, err_hdr, err_trunc, err_abort, drop_flt}, 5'd0);
    rst = 0;
    m_b = -1; m_fcnt = '0;
    clr_obs();
    send_frame(16'h0800, 8'h11, 16'd26400, 16'd34, 8, 0, 1'b0);
    chk("postrst_keeps", obs_keeps, 32'hFCFFFF0F);
    chk("postrst_abort", obs_abort, 0);

    for (int f = 0; f < 60; f++) begin
      et = ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800;
      pr = ($urandom_range(0, 9) == 0) ? 8'h06 : 8'h11;
      pt = ($urandom_range(0, 4) == 0) ? 16'd1234 : 16'd26400;
      ln = 16'($urandom_range(0, 70));
      lb = $urandom_range(1, 13);
      ab = ($urandom_range(0, 9) == 0);
      send_frame(et, pr, pt, ln, lb, 2, ab);
    end
    repeat (3) cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, dummy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
